multdiv_stage: RTL and testbench
================================

// Module: multdiv_stage
// PURPOSE
//  Iterative signed multiply/divide unit in the execute stage, beside the exception handler.
//  Takes a mul/div from the D/X latch and stalls the front end while it computes.
//  Emits one fully-resolved instruction/result pair for the X/M latch, including the
//  rstatus ($r30) override on exception. The exception handler zeroes mul/div in its own
//  path, so the X/M input mux selects md_ir/md_result when md_valid=1.
// PARAMETERS
//  MUL_OP       5'd6   aluop (DXIR[6:2]) selecting multiply when opcode DXIR[31:27]==0
//  DIV_OP       5'd7   aluop selecting divide
//  EXC_REG      5'd30  rd substituted into DXIR[26:22] on exception
//  MUL_EXC_VAL  32'd4  result written on multiply overflow
//  DIV_EXC_VAL  32'd5  result written on divide by zero
// PORTS
//  clock      in   1   rising-edge clock
//  reset_n    in   1   asynchronous active-low reset
//  DXIR       in   32  instruction in the D/X latch
//  operandA   in   32  rs value, post-bypass (signed)
//  operandB   in   32  rt value, post-bypass (signed)
//  flush      in   1   kill the in-flight op (taken branch/jump resolved this cycle)
//  stall      out  1   freeze PC, F/D and D/X latches
//  md_valid   out  1   one-cycle pulse: md_ir/md_result are valid for the X/M latch
//  md_ir      out  32  instruction to X/M (rd replaced by EXC_REG on exception)
//  md_result  out  32  value to X/M O register
// BEHAVIOUR
//  is_md = (DXIR[31:27]==0) && (DXIR[6:2]==MUL_OP || DXIR[6:2]==DIV_OP).
//  Reset values: state=IDLE, count=0, md_valid=0, md_ir=0, md_result=0.
//    stall is combinational and is 0 while reset_n=0.
//  FSM states: IDLE, BUSY, DONE.
//  IDLE
//    If is_md && !flush: stall=1 combinationally.
//    At the edge: latch DXIR, |A|, |B|, result sign, op; clear count and accumulator; go BUSY.
//    Otherwise stall=0.
//  BUSY
//    stall=1. One shift-add (mul) or restoring shift-subtract (div) step per cycle.
//    At count==31, the edge moves to DONE.
//  DONE
//    stall=0, md_valid=1 with registered md_ir/md_result. Go to IDLE unconditionally.
//    The D/X latch advances on this edge, so the same op is never re-issued.
//  Latency: issue edge, then 32 BUSY cycles, then md_valid in cycle 33 after issue
//    (the issue cycle is cycle 0). Back-to-back mul/div: the next issue happens in the
//    cycle after DONE.
//  flush in IDLE or BUSY: the next edge returns to IDLE with no md_valid; stall drops
//    the same cycle.
//  flush in DONE: ignored; the result is already committed.
//  Multiply: 64-bit signed product. Overflow when product[63:31] is not all 0s or
//    all 1s.
//  Divide: signed, quotient truncated toward zero, remainder discarded.
//    0x80000000 / -1 gives 0x80000000 with no exception.
//  Divide by zero: detected at issue. It still takes the full latency, for uniform
//    timing.
//  On exception: md_ir = DXIR with [26:22]=EXC_REG; md_result = MUL_EXC_VAL or DIV_EXC_VAL.
//  No exception and rd==0: md_result=0, md_ir unchanged.
//  Asynchronous reset mid-operation aborts to IDLE immediately; the op is lost.
//  Outputs md_ir and md_result hold their last values outside DONE. Consumers qualify
//    them with md_valid.
// TESTING
//  mul rd=3, A=7, B=-3: stall for cycles 0..32 -> md_valid at cycle 33,
//    md_result=0xFFFFFFEB (-21), md_ir rd=3.
//  mul A=0x00010000, B=0x00010000 -> md_ir[26:22]=30, md_result=4.
//  div A=100, B=0 -> md_ir[26:22]=30, md_result=5. div A=-7, B=2 -> md_result=-3,
//    no override.
//  mul rd=0, A=5, B=6 -> md_result=0, md_ir unchanged.
//  Two consecutive muls (2*3, then 4*5) -> md_valid pulses at cycles 33 and 67 with 6
//    and 20. stall=0 only in each DONE cycle.
//  reset_n low at BUSY cycle 10 -> stall=0 and md_valid=0 at once; idle after release.
//  flush at BUSY cycle 5 -> no md_valid, stall=0.

Source files
------------

// File: rtl/multdiv_stage.sv
`default_nettype none
// ============================================================================
// Module   : multdiv_stage
// Purpose  : Iterative signed multiply/divide unit in the execute stage.
//            Holds the front end while a mul/div runs for 32 step cycles, then
//            emits one resolved instruction/result pair for the X/M latch,
//            with the rd override to the status register on exception.
// Revision : 1.0 - initial release
// ============================================================================
module multdiv_stage #(
   parameter logic [4:0]  MUL_OP      = 5'd6,
   parameter logic [4:0]  DIV_OP      = 5'd7,
   parameter logic [4:0]  EXC_REG     = 5'd30,
   parameter logic [31:0] MUL_EXC_VAL = 32'd4,
   parameter logic [31:0] DIV_EXC_VAL = 32'd5
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic [31:0] DXIR,
   input  logic [31:0] operandA,
   input  logic [31:0] operandB,
   input  logic        flush,
   output logic        stall,
   output logic        md_valid,
   output logic [31:0] md_ir,
   output logic [31:0] md_result
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t      state;
   logic [4:0]  count;
   logic [31:0] ir_q;       // instruction captured at issue
   logic [31:0] opnd;       // multiplicand (mul) or divisor (div) magnitude
   logic [31:0] hi;         // product high half / partial remainder
   logic [31:0] lo;         // multiplier being consumed / dividend becoming quotient
   logic        is_mul_q;
   logic        neg_q;      // result must be negated at the end
   logic        dz_q;       // divide by zero seen at issue

   logic        is_mul_in;
   logic        is_div_in;
   logic        is_md;
   logic [31:0] a_mag;
   logic [31:0] b_mag;

   assign is_mul_in = (DXIR[31:27] == 5'd0) && (DXIR[6:2] == MUL_OP);
   assign is_div_in = (DXIR[31:27] == 5'd0) && (DXIR[6:2] == DIV_OP);
   assign is_md     = is_mul_in || is_div_in;
   // Magnitudes are unsigned, so 0x80000000 stays representable as 2^31.
   assign a_mag     = operandA[31] ? -operandA : operandA;
   assign b_mag     = operandB[31] ? -operandB : operandB;

   // One iteration of the datapath
   logic [32:0] mul_sum;
   logic [32:0] div_shift;
   logic [32:0] div_diff;
   logic        div_ge;
   logic [31:0] hi_next;
   logic [31:0] lo_next;

   assign mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : 33'd0);
   assign div_shift = {hi, lo[31]};
   assign div_diff  = div_shift - {1'b0, opnd};
   assign div_ge    = (div_shift >= {1'b0, opnd});

   // Select shift-add (mul) or restoring shift-subtract (div) step
   always_comb begin
      hi_next = 32'd0;
      lo_next = 32'd0;
      if (is_mul_q) begin
         hi_next = mul_sum[32:1];
         lo_next = {mul_sum[0], lo[31:1]};
      end else begin
         hi_next = div_ge ? div_diff[31:0] : div_shift[31:0];
         lo_next = {lo[30:0], div_ge};
      end
   end

   // Result formation from the final step's values
   logic [63:0] prod;
   logic [31:0] quot;
   logic        ovf;
   logic        exc;
   logic [31:0] ir_out;
   logic [31:0] res_val;
   logic        unused_bits;

   assign prod        = neg_q ? -{hi_next, lo_next} : {hi_next, lo_next};
   assign quot        = neg_q ? -lo_next : lo_next;
   assign ovf         = !((&prod[63:31]) || !(|prod[63:31]));
   assign exc         = is_mul_q ? ovf : dz_q;
   assign unused_bits = div_diff[32];

   // Apply exception override or the rd==0 zeroing to the outgoing pair
   always_comb begin
      ir_out  = ir_q;
      res_val = is_mul_q ? prod[31:0] : quot;
      if (exc) begin
         ir_out[26:22] = EXC_REG;
         res_val       = is_mul_q ? MUL_EXC_VAL : DIV_EXC_VAL;
      end else if (ir_q[26:22] == 5'd0) begin
         res_val = 32'd0;
      end
   end

   // Front-end hold: asserted on issue and throughout BUSY, dropped by flush or reset
   always_comb begin
      stall = 1'b0;
      if (reset_n) begin
         case (state)
            IDLE:    stall = is_md && !flush;
            BUSY:    stall = !flush;
            default: stall = 1'b0;
         endcase
      end
   end

   // Control FSM with datapath registers and registered X/M outputs
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         count     <= 5'd0;
         md_valid  <= 1'b0;
         md_ir     <= 32'd0;
         md_result <= 32'd0;
         ir_q      <= 32'd0;
         opnd      <= 32'd0;
         hi        <= 32'd0;
         lo        <= 32'd0;
         is_mul_q  <= 1'b0;
         neg_q     <= 1'b0;
         dz_q      <= 1'b0;
      end else begin
         md_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (is_md && !flush) begin
                  ir_q     <= DXIR;
                  is_mul_q <= is_mul_in;
                  neg_q    <= operandA[31] ^ operandB[31];
                  dz_q     <= is_div_in && (operandB == 32'd0);
                  opnd     <= is_mul_in ? a_mag : b_mag;
                  lo       <= is_mul_in ? b_mag : a_mag;
                  hi       <= 32'd0;
                  count    <= 5'd0;
                  state    <= BUSY;
               end
            end
            BUSY: begin
               if (flush) begin
                  state <= IDLE;
               end else begin
                  hi    <= hi_next;
                  lo    <= lo_next;
                  count <= count + 5'd1;
                  if (count == 5'd31) begin
                     state     <= DONE;
                     md_valid  <= 1'b1;
                     md_ir     <= ir_out;
                     md_result <= res_val;
                  end
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_multdiv_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_multdiv_stage
// Purpose  : Directed table-driven bench for multdiv_stage, plus sequences for
//            back-to-back issue, flush and mid-operation reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multdiv_stage;

   localparam logic [4:0] MUL = 5'd6;
   localparam logic [4:0] DIV = 5'd7;

   logic        clock    = 1'b0;
   logic        reset_n  = 1'b0;
   logic        flush    = 1'b0;
   logic [31:0] DXIR     = 32'd0;
   logic [31:0] operandA = 32'd0;
   logic [31:0] operandB = 32'd0;
   logic        stall;
   logic        md_valid;
   logic [31:0] md_ir;
   logic [31:0] md_result;

   int passed = 0;
   int total  = 0;

   multdiv_stage dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .DXIR      (DXIR),
      .operandA  (operandA),
      .operandB  (operandB),
      .flush     (flush),
      .stall     (stall),
      .md_valid  (md_valid),
      .md_ir     (md_ir),
      .md_result (md_result)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [31:0] ir;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp_ir;
      logic [31:0] exp_res;
      logic        fd;      // assert flush during the DONE cycle
   } vec_t;

   vec_t vecs[12];

   function automatic logic [31:0] mk(input logic [4:0] rd, input logic [4:0] op);
      return {5'd0, rd, 5'd1, 5'd2, 5'd0, op, 2'b00};
   endfunction

   function automatic logic [31:0] set_rd(input logic [31:0] ir, input logic [4:0] rd);
      logic [31:0] r;
      r = ir;
      r[26:22] = rd;
      return r;
   endfunction

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got === exp) passed++;
      else $display("FAIL %s: got %h expected %h", name, got, exp);
   endtask

   // Issue one op at the current cycle (called #1 after a rising edge) and
   // follow it until md_valid or the cycle budget runs out.
   task automatic do_op(input logic [31:0] ir, input logic [31:0] a, input logic [31:0] b,
                        input logic fd, output int vcyc, output logic bad_stall,
                        output logic [31:0] got_ir, output logic [31:0] got_res);
      vcyc      = -1;
      bad_stall = 1'b0;
      got_ir    = 32'd0;
      got_res   = 32'd0;
      DXIR      = ir;
      operandA  = a;
      operandB  = b;
      for (int cyc = 0; cyc < 40; cyc++) begin
         @(negedge clock);
         if (md_valid) begin
            vcyc    = cyc;
            got_ir  = md_ir;
            got_res = md_result;
            if (stall) bad_stall = 1'b1;
         end else if (!stall) begin
            bad_stall = 1'b1;
         end
         @(posedge clock);
         #1;
         flush = fd && (cyc == 32);
         if (vcyc >= 0) break;
      end
      flush = 1'b0;
   endtask

   task automatic expect_quiet(input string name);
      logic seen;
      seen = 1'b0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clock);
         if (md_valid || stall) seen = 1'b1;
      end
      check(name, {31'd0, seen}, 32'd0);
      @(posedge clock);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int          vc;
      logic        bs;
      logic [31:0] gi;
      logic [31:0] gr;

      vecs[0]  = '{mk(3, MUL), 32'd7,          32'hFFFFFFFD, mk(3, MUL),              32'hFFFFFFEB, 1'b0};
      vecs[1]  = '{mk(3, MUL), 32'h00010000,   32'h00010000, set_rd(mk(3, MUL), 30),  32'd4,        1'b0};
      vecs[2]  = '{mk(4, DIV), 32'd100,        32'd0,        set_rd(mk(4, DIV), 30),  32'd5,        1'b0};
      vecs[3]  = '{mk(4, DIV), 32'hFFFFFFF9,   32'd2,        mk(4, DIV),              32'hFFFFFFFD, 1'b0};
      vecs[4]  = '{mk(0, MUL), 32'd5,          32'd6,        mk(0, MUL),              32'd0,        1'b0};
      vecs[5]  = '{mk(5, DIV), 32'h80000000,   32'hFFFFFFFF, mk(5, DIV),              32'h80000000, 1'b0};
      vecs[6]  = '{mk(6, MUL), 32'hFFFF0000,   32'h00008000, mk(6, MUL),              32'h80000000, 1'b0};
      vecs[7]  = '{mk(6, MUL), 32'h00010000,   32'h00008000, set_rd(mk(6, MUL), 30),  32'd4,        1'b0};
      vecs[8]  = '{mk(7, DIV), 32'd7,          32'hFFFFFFFE, mk(7, DIV),              32'hFFFFFFFD, 1'b0};
      vecs[9]  = '{mk(8, DIV), 32'hFFFFFF9C,   32'hFFFFFFF9, mk(8, DIV),              32'd14,       1'b0};
      vecs[10] = '{mk(9, MUL), 32'hFFFFFFFF,   32'hFFFFFFFF, mk(9, MUL),              32'd1,        1'b1};
      vecs[11] = '{mk(0, DIV), 32'd9,          32'd0,        set_rd(mk(0, DIV), 30),  32'd5,        1'b0};

      // Reset state, with a mul sitting in D/X
      DXIR = mk(3, MUL);
      @(negedge clock);
      check("rst_stall",  {31'd0, stall},    32'd0);
      check("rst_valid",  {31'd0, md_valid}, 32'd0);
      check("rst_ir",     md_ir,             32'd0);
      check("rst_result", md_result,         32'd0);
      @(posedge clock);
      #1;
      reset_n = 1'b1;
      DXIR    = 32'd0;

      // Decode: non-zero opcode and other aluops must not stall
      DXIR = {5'd1, 5'd3, 5'd1, 5'd2, 5'd0, MUL, 2'b00};
      @(negedge clock);
      check("decode_opcode", {31'd0, stall}, 32'd0);
      DXIR = mk(3, 5'd5);
      #1;
      check("decode_aluop", {31'd0, stall}, 32'd0);
      @(posedge clock);
      #1;
      DXIR = 32'd0;

      // Table of single operations
      for (int i = 0; i < 12; i++) begin
         do_op(vecs[i].ir, vecs[i].a, vecs[i].b, vecs[i].fd, vc, bs, gi, gr);
         DXIR = 32'd0;
         check($sformatf("v%0d_cycle", i), vc, 32'd33);
         check($sformatf("v%0d_stall", i), {31'd0, bs}, 32'd0);
         check($sformatf("v%0d_ir", i),    gi, vecs[i].exp_ir);
         check($sformatf("v%0d_res", i),   gr, vecs[i].exp_res);
         if (i == 0) begin
            @(negedge clock);
            check("pulse_width", {31'd0, md_valid}, 32'd0);
            check("after_done_stall", {31'd0, stall}, 32'd0);
            check("hold_result", md_result, 32'hFFFFFFEB);
            @(posedge clock);
            #1;
         end
      end

      // Back-to-back: second op issues the cycle after the first DONE
      do_op(mk(1, MUL), 32'd2, 32'd3, 1'b0, vc, bs, gi, gr);
      check("b2b0_cycle", vc, 32'd33);
      check("b2b0_stall", {31'd0, bs}, 32'd0);
      check("b2b0_res",   gr, 32'd6);
      do_op(mk(2, MUL), 32'd4, 32'd5, 1'b0, vc, bs, gi, gr);
      DXIR = 32'd0;
      check("b2b1_cycle", vc, 32'd33);
      check("b2b1_stall", {31'd0, bs}, 32'd0);
      check("b2b1_res",   gr, 32'd20);
      check("b2b1_ir",    gi, mk(2, MUL));

      // Flush while IDLE with a mul present: no issue
      DXIR     = mk(3, MUL);
      operandA = 32'd9;
      operandB = 32'd9;
      flush    = 1'b1;
      @(negedge clock);
      check("flush_idle_stall", {31'd0, stall}, 32'd0);
      @(posedge clock);
      #1;
      flush = 1'b0;
      DXIR  = 32'd0;
      expect_quiet("flush_idle_quiet");

      // Flush at BUSY cycle 5
      DXIR = mk(3, MUL);
      for (int c = 0; c < 5; c++) begin
         @(posedge clock);
         #1;
      end
      flush = 1'b1;
      @(negedge clock);
      check("flush_busy_stall", {31'd0, stall}, 32'd0);
      @(posedge clock);
      #1;
      flush = 1'b0;
      DXIR  = 32'd0;
      expect_quiet("flush_busy_quiet");

      // Asynchronous reset at BUSY cycle 10
      DXIR     = mk(3, MUL);
      operandA = 32'd7;
      operandB = 32'hFFFFFFFD;
      for (int c = 0; c < 10; c++) begin
         @(posedge clock);
         #1;
      end
      reset_n = 1'b0;
      #1;
      check("rst_mid_stall", {31'd0, stall},    32'd0);
      check("rst_mid_valid", {31'd0, md_valid}, 32'd0);
      check("rst_mid_ir",    md_ir,             32'd0);
      @(posedge clock);
      #1;
      DXIR    = 32'd0;
      reset_n = 1'b1;
      expect_quiet("rst_mid_quiet");

      // Normal operation after the aborted op
      do_op(mk(3, MUL), 32'd7, 32'hFFFFFFFD, 1'b0, vc, bs, gi, gr);
      DXIR = 32'd0;
      check("post_rst_cycle", vc, 32'd33);
      check("post_rst_res",   gr, 32'hFFFFFFEB);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
`default_nettype wire
